// File: rtl/axis_elastic_fifo.sv
// AXI-Stream elastic FIFO: DEPTH-entry circular buffer with flush.
// Optional combinational bypass when empty: AXIS_ELASTIC_FIFO_BYPASS_EN.
module axis_elastic_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sif_tvalid,
  input  logic [TDATA_WIDTH-1:0]       sif_tdata,
  output logic                         sif_tready,
  output logic                         mif_tvalid,
  output logic [TDATA_WIDTH-1:0]       mif_tdata,
  input  logic                         mif_tready,
  input  logic                         invalidate,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TDATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   empty;
  logic                   byp;
  logic                   push, pop;
  logic                   wr_en, rd_en;

  assign empty = (count_q == '0);
  assign count = count_q;

  // Handshake outputs; reset and flush both mask the interface.
  always_comb begin
    byp        = 1'b0;
    sif_tready = ~rst & ~invalidate & (count_q < FULL);
    mif_tvalid = ~rst & ~invalidate & ~empty;
    mif_tdata  = mem_q[rd_ptr_q];
`ifdef AXIS_ELASTIC_FIFO_BYPASS_EN
    if (empty && !invalidate && !rst) begin
      byp        = 1'b1;
      mif_tvalid = sif_tvalid;
      mif_tdata  = sif_tdata;
    end
`endif
    push = sif_tvalid & sif_tready;
    pop  = mif_tvalid & mif_tready;
  end

  // A bypassed beat taken downstream never touches storage.
  assign wr_en = push & ~(byp & mif_tready);
  assign rd_en = pop & ~byp;

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (invalidate) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sif_tdata;
  end

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// Scoreboard bench for axis_elastic_fifo (DEPTH=4, 32-bit payload).
module tb_axis_elastic_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);
`ifdef AXIS_ELASTIC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sif_tvalid = 1'b0;
  logic [W-1:0]  sif_tdata = '0;
  logic          sif_tready;
  logic          mif_tvalid;
  logic [W-1:0]  mif_tdata;
  logic          mif_tready = 1'b0;
  logic          invalidate = 1'b0;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int p0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  axis_elastic_fifo #(.TDATA_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .sif_tvalid(sif_tvalid), .sif_tdata(sif_tdata), .sif_tready(sif_tready),
    .mif_tvalid(mif_tvalid), .mif_tdata(mif_tdata), .mif_tready(mif_tready),
    .invalidate(invalidate), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; every valid beat here is expected to be taken.
  task automatic step(input logic v, input logic [W-1:0] d, input logic rdy);
    sif_tvalid = v;
    sif_tdata  = d;
    mif_tready = rdy;
    @(negedge clk);
    if (v) begin
      chk("sif_tready", 32'(sif_tready), 32'd1);
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1);
    chk(name, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(count), 32'd0);
  endtask

  // Output monitor: compares every presented beat against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mif_tvalid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h want none", mif_tdata);
        end else begin
          chk("out_data", mif_tdata, exp_q[0]);
          if (mif_tready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sif_tready", 32'(sif_tready), 32'd0);
    chk("rst_mif_tvalid", 32'(mif_tvalid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill to full with downstream stalled, then drain in order.
    sif_tvalid = 1'b1;
    sif_tdata  = 32'h11;
    #1;
    chk("lat_same_cycle", 32'(mif_tvalid), 32'(BYP));
    step(1'b1, 32'h11, 1'b0);
    chk("lat_next_cycle", 32'(mif_tvalid), 32'd1);
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    step(1'b1, 32'h44, 1'b0);
    sif_tvalid = 1'b0;
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_sif_tready", 32'(sif_tready), 32'd0);
    p0 = pops;
    drain("fill_drain");
    chk("fill_pops", 32'(pops - p0), 32'd4);

    // Streaming: 16 beats back to back with downstream always ready.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'(i), 1'b1);
      if (i == 8) chk("stream_count", 32'(count), BYP ? 32'd0 : 32'd1);
    end
    step(1'b0, '0, 1'b1);
    chk("stream_pops", 32'(pops - p0), 32'd16);
    chk("stream_count_end", 32'(count), 32'd0);

    // Simultaneous push/pop at count=2 with write pointer wrapping.
    step(1'b1, 32'hA1, 1'b0);
    step(1'b1, 32'hA2, 1'b0);
    chk("pp_count0", 32'(count), 32'd2);
    step(1'b1, 32'hA3, 1'b1);
    chk("pp_count1", 32'(count), 32'd2);
    step(1'b1, 32'hA4, 1'b1);
    chk("pp_count2", 32'(count), 32'd2);
    step(1'b1, 32'hA5, 1'b1);
    chk("pp_count3", 32'(count), 32'd2);
    drain("pp_drain");

    // Flush at count=3; the next beat must be the first seen.
    step(1'b1, 32'hB1, 1'b0);
    step(1'b1, 32'hB2, 1'b0);
    step(1'b1, 32'hB3, 1'b0);
    chk("inv_pre_count", 32'(count), 32'd3);
    invalidate = 1'b1;
    sif_tvalid = 1'b1;
    sif_tdata  = 32'hCC;
    mif_tready = 1'b1;
    #1;
    chk("inv_sif_tready", 32'(sif_tready), 32'd0);
    chk("inv_mif_tvalid", 32'(mif_tvalid), 32'd0);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    invalidate = 1'b0;
    sif_tvalid = 1'b0;
    mif_tready = 1'b0;
    #1;
    chk("inv_post_count", 32'(count), 32'd0);
    chk("inv_post_mif_tvalid", 32'(mif_tvalid), 32'd0);
    p0 = pops;
    step(1'b1, 32'hAA, 1'b0);
    drain("inv_drain");
    chk("inv_pops", 32'(pops - p0), 32'd1);

    // Asynchronous reset mid-burst at count=2.
    step(1'b1, 32'hC1, 1'b0);
    step(1'b1, 32'hC2, 1'b0);
    sif_tvalid = 1'b0;
    chk("arst_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_mif_tvalid", 32'(mif_tvalid), 32'd0);
    chk("arst_sif_tready", 32'(sif_tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    p0 = pops;
    step(1'b1, 32'h5A, 1'b0);
    drain("arst_drain");
    chk("arst_pops", 32'(pops - p0), 32'd1);

`ifdef AXIS_ELASTIC_FIFO_BYPASS_EN
    // Same-cycle pass-through when empty.
    sif_tvalid = 1'b1;
    sif_tdata  = 32'h77;
    mif_tready = 1'b1;
    #1;
    chk("byp_mif_tvalid", 32'(mif_tvalid), 32'd1);
    chk("byp_mif_tdata", mif_tdata, 32'h77);
    chk("byp_count_now", 32'(count), 32'd0);
    step(1'b1, 32'h77, 1'b1);
    sif_tvalid = 1'b0;
    #1;
    chk("byp_count_after", 32'(count), 32'd0);
    chk("byp_mif_tvalid_after", 32'(mif_tvalid), 32'd0);
`endif

    step(1'b0, '0, 1'b0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_elastic_fifo.md
AXIS_ELASTIC_FIFO -- requirements
Module: axis_elastic_fifo

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, meaning the payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of storage entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sif_tvalid, input, 1, upstream data valid.
REQ-006 SHALL have port sif_tdata, input, TDATA_WIDTH, upstream payload.
REQ-007 SHALL have port sif_tready, output, 1, FIFO accepts upstream beat.
REQ-008 SHALL have port mif_tvalid, output, 1, downstream data valid.
REQ-009 SHALL have port mif_tdata, output, TDATA_WIDTH, downstream payload.
REQ-010 SHALL have port mif_tready, input, 1, downstream accepts beat.
REQ-011 SHALL have port invalidate, input, 1, synchronous flush of all held beats.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-013 SHALL define push = sif_tvalid & sif_tready and pop = mif_tvalid & mif_tready, both evaluated in the same cycle.
REQ-014 SHALL store beats in a DEPTH-entry circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL drive sif_tready = (count < DEPTH) & ~invalidate, with no combinational path from mif_tready.
REQ-016 SHALL drive mif_tvalid = (count != 0) & ~invalidate and mif_tdata = entry at read pointer (no bypass).
REQ-017 SHALL deliver beats in arrival order, without loss or duplication.
REQ-018 SHALL update count +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-019 SHALL accept push and pop in the same cycle when 0 < count < DEPTH.
REQ-020 SHALL give 1-cycle minimum latency, sif push to mif_tvalid (no bypass).
REQ-021 SHALL sustain 1 beat/cycle throughput whenever mif_tready is held high.
REQ-022 SHALL keep mif_tdata stable while mif_tvalid=1 and mif_tready=0.
REQ-023 SHALL, on a cycle with invalidate=1, perform no push or pop, then reset both pointers and count to 0 at the next edge.
REQ-024 SHALL let invalidate override all other activity in that cycle, including a full buffer or a pending bypass.

Reset
REQ-025 SHALL, while rst=1, force count=0, read and write pointers to 0, sif_tready=0 and mif_tvalid=0.
REQ-026 SHALL NOT reset storage contents; mif_tdata is don't-care while mif_tvalid=0.
REQ-027 SHALL drop all held beats when rst asserts mid-operation, and SHALL accept data the first cycle after rst deasserts.

Configuration
REQ-028 SHALL provide macro AXIS_ELASTIC_FIFO_BYPASS_EN.
REQ-029 SHALL, with the macro defined and count=0 and invalidate=0, drive mif_tvalid=sif_tvalid and mif_tdata=sif_tdata combinationally.
REQ-030 SHALL, in that bypass case, not write the beat to storage when mif_tready=1, and write it normally when mif_tready=0.
REQ-031 SHALL, with the macro undefined, behave exactly as REQ-016 and REQ-020 with no combinational sif-to-mif path.

Verification
REQ-032 SHALL cover: DEPTH=4; push 0x11,0x22,0x33,0x44 with mif_tready=0 -> count=4, sif_tready=0; then mif_tready=1 -> outputs 0x11..0x44 in order, count returns to 0.
REQ-033 SHALL cover: continuous sif_tvalid with mif_tready=1, 16 beats 0..15 -> 16 beats out 0..15, one per cycle after first-beat latency (1 cycle, or 0 with bypass).
REQ-034 SHALL cover: count=2 with push and pop in the same cycle -> count stays 2 and order is preserved, with pointer wrap exercised past index 3.
REQ-035 SHALL cover: count=3 and invalidate=1 for one cycle -> sif_tready=0 and mif_tvalid=0 that cycle, count=0 next cycle, and the next pushed beat 0xAA is the first output.
REQ-036 SHALL cover: rst asserted asynchronously mid-burst at count=2 -> immediately count=0 and mif_tvalid=0; after release, beat 0x5A passes normally.
REQ-037 SHALL cover: with the bypass macro, count=0, sif_tvalid=1, data 0x77, mif_tready=1 -> mif_tvalid=1 with 0x77 in the same cycle and count stays 0.
